// File: rtl/cal_pkg.sv
// cal_pkg: token and state encodings plus width helpers for bcd_calc_seq.
package cal_pkg;
   typedef enum logic [3:0] {
      TK_MUL = 4'd10,
      TK_ADD = 4'd11,
      TK_EQ  = 4'd12,
      TK_SUB = 4'd13,
      TK_CLR = 4'd14,
      TK_DIV = 4'd15
   } tok_e;

   typedef enum logic [2:0] {ENT_A, ENT_B, EXEC, CONV, DONE} state_e;

   function automatic int aw_of(input int digits);
      return $clog2(10 ** digits);
   endfunction

   function automatic int pw_of(input int digits);
      return $clog2(10 ** (2 * digits));
   endfunction
endpackage

// File: rtl/bcd_dabble.sv
// bcd_dabble: iterative double-dabble, one bit per cycle; bcd is valid when done pulses.
module bcd_dabble #(
   parameter int PW = 14,
   parameter int RD = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [PW-1:0]   bin,
   output logic            busy,
   output logic            done,
   output logic [4*RD-1:0] bcd
);
   localparam int CW = $clog2(PW + 1);

   logic [PW-1:0]   sh;
   logic [CW-1:0]   cnt;
   logic [4*RD-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < RD; i++)
         adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sh   <= '0;
         cnt  <= '0;
         bcd  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            sh   <= bin;
            bcd  <= '0;
            cnt  <= CW'(PW);
            busy <= 1'b1;
         end else if (busy) begin
            bcd <= {adj[4*RD-2:0], sh[PW-1]};
            sh  <= {sh[PW-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
endmodule

// File: rtl/bcd_calc_seq.sv
// bcd_calc_seq: token-driven multi-digit BCD calculator with valid/ready result port.
// Define CAL_DIV_EN to build the restoring divider; otherwise DIV always reports an error.
module bcd_calc_seq
   import cal_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int AW = aw_of(DIGITS),
   parameter int PW = pw_of(DIGITS),
   localparam int RD = 2 * DIGITS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tok_valid,
   input  logic [3:0]      tok_data,
   output logic            tok_ready,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [4*RD-1:0] res_bcd,
   output logic            res_sign,
   output logic            res_err
);
   localparam int CW = $clog2(AW + 1);
   localparam logic [2:0] DG = 3'(DIGITS);

   state_e          state;
   tok_e            op;
   logic [AW-1:0]   a, b, dsel;
   logic [AW+3:0]   d10;
   logic [2:0]      na, nb;
   logic [PW-1:0]   acc, mc, acc_m, mres, dab_in;
   logic [CW-1:0]   cnt;
   logic            sgn, is_dig, is_op, last, div_err, dab_start, dab_busy, dab_done;
   logic [4*RD-1:0] dab_bcd;
`ifdef CAL_DIV_EN
   logic [AW:0]     r_sh, r_nx;
   logic [AW-1:0]   q_nx;
   logic            ge;
`endif

   assign tok_ready = state == ENT_A || state == ENT_B;
   assign is_dig    = tok_data < 4'd10;
   assign is_op     = tok_data == TK_MUL || tok_data == TK_ADD || tok_data == TK_SUB || tok_data == TK_DIV;
   assign dsel      = state == ENT_A ? a : b;
   assign d10       = {1'b0, dsel, 3'b0} + {3'b0, dsel, 1'b0} + {{AW{1'b0}}, tok_data};

   always_comb begin
      acc_m = acc + (b[0] ? mc : '0);
      last  = cnt == CW'(AW - 1);
`ifdef CAL_DIV_EN
      // remainder lives in the low bits of acc, quotient shifts into a
      r_sh    = {acc[AW-1:0], a[AW-1]};
      ge      = r_sh >= {1'b0, b};
      r_nx    = ge ? r_sh - {1'b0, b} : r_sh;
      q_nx    = {a[AW-2:0], ge};
      mres    = op == TK_DIV ? PW'(q_nx) : acc_m;
      div_err = op == TK_DIV && b == '0;
`else
      mres    = acc_m;
      div_err = op == TK_DIV;
`endif
      dab_in    = op == TK_ADD ? PW'(a) + PW'(b) :
                  op == TK_SUB ? (a < b ? PW'(b - a) : PW'(a - b)) : mres;
      dab_start = state == EXEC && !div_err && !dab_busy && (op == TK_ADD || op == TK_SUB || last);
   end

   bcd_dabble #(.PW(PW), .RD(RD)) u_dabble (
      .clk   (clk),
      .rst   (rst),
      .start (dab_start),
      .bin   (dab_in),
      .busy  (dab_busy),
      .done  (dab_done),
      .bcd   (dab_bcd)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= ENT_A;
         op        <= TK_ADD;
         a         <= '0;
         b         <= '0;
         na        <= '0;
         nb        <= '0;
         acc       <= '0;
         mc        <= '0;
         cnt       <= '0;
         sgn       <= 1'b0;
         res_valid <= 1'b0;
         res_bcd   <= '0;
         res_sign  <= 1'b0;
         res_err   <= 1'b0;
      end else
         case (state)
            ENT_A:
               if (tok_valid) begin
                  if (is_dig) begin
                     if (na < DG) begin
                        a  <= d10[AW-1:0];
                        na <= na + 3'd1;
                     end
                  end else if (is_op) begin
                     op    <= tok_e'(tok_data);
                     state <= ENT_B;
                  end else if (tok_data == TK_CLR) begin
                     a  <= '0;
                     na <= '0;
                  end
               end
            ENT_B:
               if (tok_valid) begin
                  if (is_dig) begin
                     if (nb < DG) begin
                        b  <= d10[AW-1:0];
                        nb <= nb + 3'd1;
                     end
                  end else if (is_op) begin
                     if (nb == '0) op <= tok_e'(tok_data);
                  end else if (tok_data == TK_EQ) begin
                     acc   <= '0;
                     mc    <= PW'(a);
                     cnt   <= '0;
                     state <= EXEC;
                  end else begin
                     a     <= '0;
                     b     <= '0;
                     na    <= '0;
                     nb    <= '0;
                     op    <= TK_ADD;
                     state <= ENT_A;
                  end
               end
            EXEC: begin
               sgn <= op == TK_SUB && a < b;
               if (div_err) state <= DONE;
               else if (op == TK_ADD || op == TK_SUB) state <= CONV;
               else begin
`ifdef CAL_DIV_EN
                  if (op == TK_DIV) begin
                     acc <= PW'(r_nx);
                     a   <= q_nx;
                  end else begin
                     acc <= acc_m;
                     mc  <= mc << 1;
                     b   <= b >> 1;
                  end
`else
                  acc <= acc_m;
                  mc  <= mc << 1;
                  b   <= b >> 1;
`endif
                  cnt <= cnt + CW'(1);
                  if (last) state <= CONV;
               end
            end
            CONV:
               if (dab_done) begin
                  res_bcd   <= dab_bcd;
                  res_sign  <= sgn;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            DONE:
               // entering DONE with res_valid low only happens on the error path
               if (!res_valid) begin
                  res_valid <= 1'b1;
                  res_bcd   <= '0;
                  res_sign  <= 1'b0;
                  res_err   <= 1'b1;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  a         <= '0;
                  b         <= '0;
                  na        <= '0;
                  nb        <= '0;
                  op        <= TK_ADD;
                  state     <= ENT_A;
               end
            default: state <= ENT_A;
         endcase
endmodule

// File: tb/tb_bcd_calc_seq.sv
// tb_bcd_calc_seq: directed expressions with a scoreboard checked by an independent result monitor.
`timescale 1ns/1ps
module tb_bcd_calc_seq;
   localparam logic [3:0] MUL = 4'd10, ADD = 4'd11, EQ = 4'd12, SUB = 4'd13, CLR = 4'd14, DIV = 4'd15;
   localparam int LAS = 16;  // ADD/SUB: 1 + 14 + 1
   localparam int LMD = 22;  // MUL/DIV: 7 + 14 + 1
   localparam int LER = 2;

   typedef struct {
      logic [15:0] bcd;
      logic        sign;
      logic        err;
      int          lat;
      time         t0;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          tests = 0, fails = 0;
   logic        clk = 1'b0, rst = 1'b1, tok_valid = 1'b0, res_ready = 1'b0;
   logic [3:0]  tok_data = '0;
   logic        tok_ready, res_valid, res_sign, res_err;
   logic [15:0] res_bcd;
   time         t_acc;
   logic        pv = 1'b0, hs, he;
   logic [15:0] hb;

   always #5 clk = ~clk;

   bcd_calc_seq dut (
      .clk       (clk),
      .rst       (rst),
      .tok_valid (tok_valid),
      .tok_data  (tok_data),
      .tok_ready (tok_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_bcd   (res_bcd),
      .res_sign  (res_sign),
      .res_err   (res_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (res_valid && !pv) begin
         if (sb.size() == 0) check("unexpected_result", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check("bcd", 32'(res_bcd), 32'(e.bcd));
            check("sign", 32'(res_sign), 32'(e.sign));
            check("err", 32'(res_err), 32'(e.err));
            check("latency", 32'(($time - 5 - e.t0) / 10), 32'(e.lat));
         end
         hb = res_bcd;
         hs = res_sign;
         he = res_err;
      end else if (res_valid) begin
         check("hold_bcd", 32'(res_bcd), 32'(hb));
         check("hold_sign", 32'(res_sign), 32'(hs));
         check("hold_err", 32'(res_err), 32'(he));
         check("hold_tok_ready", 32'(tok_ready), 32'd0);
      end
      pv = res_valid;
   end

   task automatic send(input logic [3:0] t);
      int k = 0;
      @(negedge clk);
      tok_valid = 1'b1;
      tok_data  = t;
      while (!tok_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!tok_ready) check("tok_accept_timeout", 32'd0, 32'd1);
      t_acc = $time + 5;
      @(posedge clk);
      #1 tok_valid = 1'b0;
   endtask

   task automatic eq(input logic [15:0] bcd, input logic sign, input logic err, input int lat);
      send(EQ);
      sb.push_back('{bcd, sign, err, lat, t_acc});
   endtask

   task automatic take(input int hold);
      int k = 0;
      while (!res_valid && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("result_timeout", 32'(res_valid), 32'd1);
      repeat (hold) @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      #3;
      check("rst_tok_ready", 32'(tok_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_bcd", 32'(res_bcd), 32'd0);
      check("rst_res_sign", 32'(res_sign), 32'd0);
      check("rst_res_err", 32'(res_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      send(1); send(2); send(MUL); send(3); send(4); eq(16'h0408, 1'b0, 1'b0, LMD); take(0);
      send(5); send(SUB); send(2); send(7); eq(16'h0022, 1'b1, 1'b0, LAS); take(2);

      // reset while the converter is running: outputs drop at once, no stale result follows
      send(1); send(2); send(MUL); send(3); send(4); send(EQ);
      repeat (12) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_tok_ready", 32'(tok_ready), 32'd1);
      check("mid_rst_res_valid", 32'(res_valid), 32'd0);
      check("mid_rst_res_bcd", 32'(res_bcd), 32'd0);
      check("mid_rst_res_sign", 32'(res_sign), 32'd0);
      check("mid_rst_res_err", 32'(res_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      send(2); send(5); send(SUB); send(2); send(5); eq(16'h0000, 1'b0, 1'b0, LAS); take(0);

      send(9); send(9); send(MUL); send(9); send(9); eq(16'h9801, 1'b0, 1'b0, LMD); take(10);
      send(7); send(DIV); send(0); eq(16'h0000, 1'b0, 1'b1, LER); take(3);
`ifdef CAL_DIV_EN
      send(7); send(DIV); send(2); eq(16'h0003, 1'b0, 1'b0, LMD); take(0);
      send(9); send(9); send(DIV); send(7); eq(16'h0014, 1'b0, 1'b0, LMD); take(1);
`else
      send(7); send(DIV); send(2); eq(16'h0000, 1'b0, 1'b1, LER); take(0);
      send(9); send(9); send(DIV); send(7); eq(16'h0000, 1'b0, 1'b1, LER); take(1);
`endif
      send(1); send(2); send(3); send(ADD); send(ADD); send(SUB); send(4); eq(16'h0008, 1'b0, 1'b0, LAS); take(0);
      send(4); send(ADD); send(5); send(CLR); send(6); send(ADD); send(1); eq(16'h0007, 1'b0, 1'b0, LAS); take(0);
      send(EQ); send(3); send(ADD); eq(16'h0003, 1'b0, 1'b0, LAS); take(0);
      send(9); send(9); send(ADD); send(9); send(9); eq(16'h0198, 1'b0, 1'b0, LAS); take(0);
      send(CLR); send(4); send(2); send(SUB); send(4); send(2); send(1); eq(16'h0000, 1'b0, 1'b0, LAS); take(0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/bcd_calc_seq.md
# bcd_calc_seq

Sequential, parametrised BCD calculator that sits behind the UART receiver's character decoder. It consumes one 4-bit key token per handshake: multi-digit operand A, an operator, multi-digit operand B, then '='. It evaluates the expression over multiple cycles and presents a signed BCD result with a valid/ready handshake to the UART transmit/display path. This is the successor to the single-digit combinational calculator: operand width, multi-cycle arithmetic and flow control are new.

## Interface
- DIGITS, 2, max decimal digits per operand (1..4); result has RD = 2*DIGITS digits
- AW, $clog2(10**DIGITS), derived: operand binary width
- PW, $clog2(10**RD), derived: result binary width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- tok_valid  in  1  token present
- tok_data  in  4  token code
- tok_ready  out  1  block accepts a token this cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_bcd  out  4*RD  result magnitude, digit 0 = LSB nibble
- res_sign  out  1  1 = negative
- res_err  out  1  1 = invalid operation (divide by zero / division disabled)

## Operation
- Token codes: 0-9 digit, 10 MUL, 11 ADD, 12 EQ, 13 SUB, 14 CLR, 15 DIV.
- Token accepted on a rising clk edge with tok_valid & tok_ready. tok_ready = 1 only in ENT_A and ENT_B.
- States: ENT_A, ENT_B, EXEC, CONV, DONE.
- ENT_A:
  - Digit: A = A*10 + d. Digits beyond DIGITS are dropped.
  - Operator: latch op, go to ENT_B. With no digits entered, A = 0.
  - EQ: ignored.
  - CLR: A = 0.
- ENT_B:
  - Digit: B = B*10 + d, same dropping rule.
  - Operator with zero B digits: replaces the latched op. With ≥1 B digit: ignored.
  - EQ: go to EXEC. With no B digits, B = 0.
  - CLR: clears A, B and op, and returns to ENT_A.
- EXEC:
  - ADD: single cycle, A+B.
  - SUB: single cycle. Sign = (A<B), magnitude = |A−B|.
  - MUL: shift-add, AW cycles.
  - DIV: restoring division, AW cycles, quotient only (remainder discarded).
  - DIV with B = 0: res_err = 1, magnitude 0, sign 0. Skips CONV and goes to DONE after 1 cycle.
- CONV: iterative double-dabble of the PW-bit magnitude into RD digits, PW cycles.
- DONE:
  - res_valid = 1, held stable until res_ready.
  - On handshake: go to ENT_A with A, B, op cleared.
  - res_bcd, res_sign and res_err hold their values until the next result is produced.
- All arithmetic is unsigned binary internally. The magnitude never exceeds 10**RD − 1, so there is no overflow.

## Timing
- Reset values:
  - State ENT_A.
  - tok_ready = 1, res_valid = 0, res_bcd = 0, res_sign = 0, res_err = 0.
  - A = B = 0, op = ADD.
- Reset is honoured in any state, including mid-EXEC and mid-CONV. No partial result is presented afterwards.
- E = 1 for ADD/SUB, E = AW for MUL/DIV.
- res_valid rises exactly E + PW + 1 cycles after the EQ-accept edge. The divide-by-zero path takes 2 cycles.
- res_ready high while res_valid is low has no effect.
- Tokens offered while tok_ready = 0 are not consumed; the producer must hold them.

## Configuration
- CAL_DIV_EN defined: the DIV datapath is compiled in as above.
- CAL_DIV_EN undefined:
  - No divider logic is built.
  - Token 15 is still accepted as an operator.
  - EQ then takes the error path: res_err = 1, latency 2.

## Structure
- Package cal_pkg holds:
  - enum typedef of the token codes.
  - enum typedef of the states.
  - Helper functions for AW/PW derivation.
- Sub-module bcd_dabble: iterative binary-to-BCD converter.
  - Parameters PW and RD.
  - Ports: start/busy/done.
  - Used for CONV; verified standalone.

## Test plan
- DIGITS=2. Tokens 1,2,MUL,3,4,EQ → after AW+PW+1 cycles: res_bcd = 0408, sign 0, err 0.
- Tokens 5,SUB,2,7,EQ → res_bcd = 0022, sign 1, latency PW+2.
- Tokens 9,9,MUL,9,9,EQ → 9801. Hold res_ready low for 10 cycles: outputs stable, tok_ready = 0.
- Tokens 7,DIV,0,EQ → err 1, bcd 0000, res_valid 2 cycles after EQ. With CAL_DIV_EN undefined, 7,DIV,2,EQ gives the same error response, and 7,DIV,2 with the macro defined gives 0003.
- Tokens 1,2,3,ADD,ADD,SUB,4,EQ → A = 12 (third digit dropped), op SUB, result 0008, sign 0.
- Tokens 4,ADD,5 then CLR, then 6,ADD,1,EQ → 0007.
- Assert rst mid-CONV → all outputs return to reset values immediately; the next expression computes correctly.
